// File: rtl/mux_scan_ctrl_if.sv
// Handshake/bus bundle between a scan requester and mux_scan_ctrl.
// chan_mask is present only when SCAN_MASK_EN is defined.
interface mux_scan_ctrl_if;
  logic       start;
  logic       mux_out;
  logic [1:0] sel;
  logic       busy;
  logic       done;
  logic [3:0] result;
`ifdef SCAN_MASK_EN
  logic [3:0] chan_mask;

  modport master (
    output start, mux_out, chan_mask,
    input  sel, busy, done, result
  );
  modport slave (
    input  start, mux_out, chan_mask,
    output sel, busy, done, result
  );
`else
  modport master (
    output start, mux_out,
    input  sel, busy, done, result
  );
  modport slave (
    input  start, mux_out,
    output sel, busy, done, result
  );
`endif
endinterface

// File: rtl/mux_scan_ctrl.sv
// Scan sequencer for a 4:1 bit mux: steps sel, waits SETTLE_CYC cycles, samples mux_out and
// publishes all four bits at once. Optional channel skipping under SCAN_MASK_EN.
module mux_scan_ctrl #(
  parameter int unsigned SETTLE_CYC = 2
) (
  input logic           clk,
  input logic           rst_n,
  mux_scan_ctrl_if.slave bus
);

  localparam logic [3:0] SettleLast = 4'(SETTLE_CYC - 1);

  typedef enum logic [1:0] {StIdle, StSettle, StSample} state_e;

  state_e     state_q, state_d;
  logic [1:0] sel_q, sel_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic [3:0] result_q, result_d;
  logic [3:0] shadow_q, shadow_d;
  logic [3:0] cnt_q, cnt_d;
  logic       empty_q, empty_d;

  logic [3:0] start_mask;
  logic [3:0] skip;
  logic [1:0] first_chan;
  logic [1:0] next_chan;
  logic       any_chan;
  logic       any_left;
  logic       accept;

  assign accept = (state_q == StIdle) && !empty_q && bus.start;

`ifdef SCAN_MASK_EN
  logic [3:0] mask_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mask_q <= '0;
    end else if (accept) begin
      mask_q <= bus.chan_mask;
    end
  end

  assign start_mask = bus.chan_mask;
  assign skip       = mask_q;
`else
  assign start_mask = '0;
  assign skip       = '0;
`endif

  assign any_chan = ~&start_mask;

  // Lowest unmasked channel for a new scan, and next unmasked channel above sel.
  always_comb begin
    first_chan = '0;
    next_chan  = '0;
    any_left   = 1'b0;
    for (int i = 3; i >= 0; i--) begin
      if (!start_mask[i]) begin
        first_chan = 2'(i);
      end
      if (!skip[i] && (i > int'(sel_q))) begin
        next_chan = 2'(i);
        any_left  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      sel_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= '0;
      shadow_q <= '0;
      cnt_q    <= '0;
      empty_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      sel_q    <= sel_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      result_q <= result_d;
      shadow_q <= shadow_d;
      cnt_q    <= cnt_d;
      empty_q  <= empty_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    sel_d    = sel_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    result_d = result_q;
    shadow_d = shadow_q;
    cnt_d    = cnt_q;
    empty_d  = 1'b0;
    case (state_q)
      StIdle: begin
        if (empty_q) begin
          // Fully masked scan completes one edge after acceptance.
          done_d   = 1'b1;
          busy_d   = 1'b0;
          result_d = '0;
        end else if (accept) begin
          busy_d   = 1'b1;
          shadow_d = '0;
          cnt_d    = '0;
          sel_d    = first_chan;
          if (any_chan) begin
            state_d = StSettle;
          end else begin
            empty_d = 1'b1;
          end
        end
      end
      StSettle: begin
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == SettleLast) begin
          state_d = StSample;
        end
      end
      StSample: begin
        shadow_d[sel_q] = bus.mux_out;
        if (any_left) begin
          sel_d   = next_chan;
          cnt_d   = '0;
          state_d = StSettle;
        end else begin
          result_d = shadow_d;
          done_d   = 1'b1;
          busy_d   = 1'b0;
          sel_d    = '0;
          state_d  = StIdle;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  assign bus.sel    = sel_q;
  assign bus.busy   = busy_q;
  assign bus.done   = done_q;
  assign bus.result = result_q;

endmodule

// File: tb/tb_mux_scan_ctrl.sv
// Directed bench for mux_scan_ctrl: expected (result, done edge) pairs go into a queue that a
// forked monitor drains whenever done is seen. Mask cases run when SCAN_MASK_EN is defined.
module tb_mux_scan_ctrl;

  typedef struct {
    logic [3:0] res;
    int         edge_n;
  } exp_t;

  logic       clk;
  logic       rst_n;
  logic [3:0] mux_a;
  int         edge_cnt = 0;
  int         total = 0;
  int         bad = 0;
  exp_t       exp_q[$];

  mux_scan_ctrl_if bus ();

  mux_scan_ctrl #(
    .SETTLE_CYC(2)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  // 4:1 bit mux being scanned.
  always_comb bus.mux_out = mux_a[bus.sel];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (edge %0d)", name, act, exp, edge_cnt);
    end
  endtask

  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clk);
      if (bus.done === 1'b1) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_done: got done=1 at edge %0d want no done", edge_cnt);
        end else begin
          e = exp_q.pop_front();
          check("result", 32'(bus.result), 32'(e.res));
          check("done_edge", 32'(edge_cnt), 32'(e.edge_n));
          check("busy_at_done", 32'(bus.busy), 32'd0);
        end
      end
    end
  endtask

  // Call at a negedge: start is seen by the next posedge (E0).
  task automatic issue(input logic [3:0] a, input logic [3:0] res, input int lat);
    exp_t e;
    mux_a     = a;
    bus.start = 1'b1;
    e.res     = res;
    e.edge_n  = edge_cnt + 1 + lat;
    exp_q.push_back(e);
  endtask

  task automatic drain(input int budget);
    int b;
    b = budget;
    while (exp_q.size() != 0 && b > 0) begin
      @(negedge clk);
      b--;
    end
    @(negedge clk);
    check("drain", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    rst_n     = 1'b1;
    bus.start = 1'b0;
    mux_a     = 4'b0000;
`ifdef SCAN_MASK_EN
    bus.chan_mask = 4'b0000;
`endif
    fork
      monitor();
    join_none

    // Reset asserted between edges takes effect without a clock edge.
    #2 rst_n = 1'b0;
    #1;
    check("rst_sel", 32'(bus.sel), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_done", 32'(bus.done), 32'd0);
    check("rst_result", 32'(bus.result), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Basic scan: sel steps every 3 cycles, result = a at E12.
    issue(4'b1010, 4'b1010, 12);
    @(negedge clk);
    bus.start = 1'b0;
    for (int k = 0; k < 12; k++) begin
      if (k > 0) @(negedge clk);
      check($sformatf("basic_sel_k%0d", k), 32'(bus.sel), 32'(k / 3));
      check($sformatf("basic_busy_k%0d", k), 32'(bus.busy), 32'd1);
    end
    drain(40);
    repeat (3) @(negedge clk);
    check("hold_result", 32'(bus.result), 32'b1010);
    check("idle_busy", 32'(bus.busy), 32'd0);
    check("idle_sel", 32'(bus.sel), 32'd0);

    // Back-to-back: start held high, second done 13 edges after the first.
    issue(4'b1100, 4'b1100, 12);
    begin
      exp_t e2;
      e2.res    = 4'b0101;
      e2.edge_n = edge_cnt + 1 + 25;
      exp_q.push_back(e2);
    end
    repeat (13) @(negedge clk);
    mux_a = 4'b0101;
    repeat (13) @(negedge clk);
    bus.start = 1'b0;
    drain(40);
    repeat (20) @(negedge clk);

    // Start during a scan is ignored.
    issue(4'b0110, 4'b0110, 12);
    @(negedge clk);
    bus.start = 1'b0;
    repeat (3) @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    drain(40);
    repeat (20) @(negedge clk);
    check("ignored_result", 32'(bus.result), 32'b0110);

    // Reset mid-scan aborts; result cleared; a fresh scan still works.
    mux_a     = 4'b1111;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (6) @(negedge clk);
    check("mid_sel", 32'(bus.sel), 32'd2);
    #2 rst_n = 1'b0;
    #1;
    check("abort_result", 32'(bus.result), 32'd0);
    check("abort_busy", 32'(bus.busy), 32'd0);
    check("abort_sel", 32'(bus.sel), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    check("post_abort_result", 32'(bus.result), 32'd0);
    issue(4'b1111, 4'b1111, 12);
    @(negedge clk);
    bus.start = 1'b0;
    drain(40);

    issue(4'b0001, 4'b0001, 12);
    @(negedge clk);
    bus.start = 1'b0;
    drain(40);

`ifdef SCAN_MASK_EN
    // Mask 0110: visit channels 0 and 3 only.
    bus.chan_mask = 4'b0110;
    issue(4'b1111, 4'b1001, 6);
    @(negedge clk);
    bus.start     = 1'b0;
    bus.chan_mask = 4'b0000;
    for (int k = 0; k < 6; k++) begin
      if (k > 0) @(negedge clk);
      check($sformatf("mask_sel_k%0d", k), 32'(bus.sel), (k < 3) ? 32'd0 : 32'd3);
    end
    drain(40);

    // All channels masked: done one edge after acceptance, result 0.
    bus.chan_mask = 4'b1111;
    issue(4'b1111, 4'b0000, 1);
    @(negedge clk);
    bus.start     = 1'b0;
    bus.chan_mask = 4'b0000;
    drain(40);
    repeat (5) @(negedge clk);
`endif

    repeat (5) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
